// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   // Fetch sequencer states; encoding is visible on state_o.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer in front of a one-cycle synchronous ROM.
// Owns the PC, issues one word address per cycle, tags returning words with
// their PC, and hands them to decode over valid/ready. A stalled word is kept
// alive by re-issuing its own address so the ROM output stays put. Redirects
// squash the in-flight word; misaligned or out-of-range fetches trap.
module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              IMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            halt_req,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            fault,
   output logic [XLEN-1:0] fault_pc,
   output logic [1:0]      state_o,
   output logic [XLEN-1:0] fetch_count
);

   // One past the last legal byte address, kept one bit wider so huge ROMs
   // cannot wrap the comparison.
   localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(INSTR_BYTES);

   // Word-aligned and inside the ROM.
   function automatic logic addr_legal(input logic [XLEN-1:0] a);
      return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIMIT);
   endfunction

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
   logic            rsp_vld_reg, rsp_vld_next;
   logic            fault_reg, fault_next;
   logic [XLEN-1:0] fault_pc_reg, fault_pc_next;
   logic [XLEN-1:0] fetch_count_reg, fetch_count_next;

   logic            stall;
   logic            handshake;
   logic [XLEN-1:0] issue_addr;

   // A redirect kills the word currently on imem_rdata in the same cycle.
   assign if_valid   = (state_reg == FETCH) && rsp_vld_reg && !redirect_valid;
   assign stall      = if_valid && !if_ready;
   assign handshake  = if_valid && if_ready;
   assign issue_addr = redirect_valid ? redirect_pc :
                       stall          ? rsp_pc_reg  : fetch_pc_reg;

   assign imem_addr   = issue_addr;
   assign if_instr    = imem_rdata;
   assign if_pc       = rsp_pc_reg;
   assign fault       = fault_reg;
   assign fault_pc    = fault_pc_reg;
   assign state_o     = state_reg;
   assign fetch_count = fetch_count_reg;

   // Next-state: redirect beats halt, halt beats the legality check.
   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      rsp_vld_next     = rsp_vld_reg;
      fault_next       = fault_reg;
      fault_pc_next    = fault_pc_reg;
      fetch_count_next = fetch_count_reg + {{(XLEN-1){1'b0}}, handshake};

      case (state_reg)
         IDLE, HALTED: begin
            rsp_vld_next = 1'b0;
            if (redirect_valid) begin
               fetch_pc_next = redirect_pc;
            end
            if (start && !halt_req) begin
               state_next = FETCH;
            end
         end

         FETCH: begin
            if (halt_req && !stall) begin
               // Stop only once any stalled word has been taken.
               state_next   = HALTED;
               rsp_vld_next = 1'b0;
               if (redirect_valid) begin
                  fetch_pc_next = redirect_pc;
               end
            end else if (addr_legal(issue_addr)) begin
               // A stalled re-issue rewrites the same values, so it is harmless.
               rsp_pc_next   = issue_addr;
               rsp_vld_next  = 1'b1;
               fetch_pc_next = issue_addr + XLEN'(INSTR_BYTES);
            end else begin
               state_next    = FAULT;
               fault_next    = 1'b1;
               fault_pc_next = issue_addr;
               rsp_vld_next  = 1'b0;
            end
         end

         FAULT: begin
            // Only a legal redirect gets out; start is ignored here.
            if (redirect_valid) begin
               if (addr_legal(redirect_pc)) begin
                  state_next    = FETCH;
                  fault_next    = 1'b0;
                  rsp_pc_next   = redirect_pc;
                  rsp_vld_next  = 1'b1;
                  fetch_pc_next = redirect_pc + XLEN'(INSTR_BYTES);
               end else begin
                  fault_pc_next = redirect_pc;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         rsp_vld_reg     <= 1'b0;
         fault_reg       <= 1'b0;
         fault_pc_reg    <= '0;
         fetch_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         rsp_vld_reg     <= rsp_vld_next;
         fault_reg       <= fault_next;
         fault_pc_reg    <= fault_pc_next;
         fetch_count_reg <= fetch_count_next;
      end
   end

endmodule
